// File: rtl/cordic_vector.sv
// Vectoring CORDIC: (x,y) Q2.14 -> magnitude Q2.14 and atan2 angle Q3.13 (gain scaling under CORDIC_VECTOR_GAIN_COMP_EN).
// Latency: ITER+1 cycles from the en edge to the done edge, ITER+2 with gain compensation.
// Backpressure: none; en is ignored while busy except in the DONE cycle, where it starts the next operation.
module cordic_vector #(
    parameter int ITER = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic [15:0] mag,
    output logic [15:0] ang,
    output logic        done,
    output logic        busy
);

    localparam logic [3:0]         LAST    = 4'(ITER - 1);
    localparam logic signed [15:0] HALF_PI = 16'sh3244;
    localparam logic signed [15:0] PI      = 16'sh6488;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE, ROT, GAIN, DONE} state_t;
    localparam logic signed [33:0] KGAIN = 34'sd9949;
    logic signed [33:0] prod;
    logic signed [18:0] g_q;
`else
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic               start;
    logic signed [18:0] x_q, y_q;
    logic signed [15:0] z_q;
    logic [3:0]         cnt_q;
    logic               zero_q;

    logic signed [18:0] xs, ys, px, py;
    logic signed [15:0] pz;
    logic signed [18:0] x_sh, y_sh, x_n, y_n, src;
    logic signed [15:0] z_n, ang_c;
    logic [15:0]        mag_c;

    function automatic logic signed [15:0] atan_rom(input logic [3:0] i);
        case (i)
            4'd0:    atan_rom = 16'sd6434;
            4'd1:    atan_rom = 16'sd3798;
            4'd2:    atan_rom = 16'sd2007;
            4'd3:    atan_rom = 16'sd1019;
            4'd4:    atan_rom = 16'sd511;
            4'd5:    atan_rom = 16'sd256;
            4'd6:    atan_rom = 16'sd128;
            4'd7:    atan_rom = 16'sd64;
            4'd8:    atan_rom = 16'sd32;
            4'd9:    atan_rom = 16'sd16;
            4'd10:   atan_rom = 16'sd8;
            4'd11:   atan_rom = 16'sd4;
            4'd12:   atan_rom = 16'sd2;
            4'd13:   atan_rom = 16'sd1;
            default: atan_rom = 16'sd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                start   = 1'b1;
                state_d = ROT;
            end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            ROT:  if (cnt_q == LAST) state_d = GAIN;
            GAIN: state_d = DONE;
`else
            ROT:  if (cnt_q == LAST) state_d = DONE;
`endif
            DONE: begin
                start   = en;
                state_d = en ? ROT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Left-half-plane inputs are turned by -/+90 degrees so the iterations always converge.
    always_comb begin
        xs = {{3{x_in[15]}}, x_in};
        ys = {{3{y_in[15]}}, y_in};
        px = xs;
        py = ys;
        pz = 16'sd0;
        if (x_in[15]) begin
            if (!y_in[15]) begin
                px = ys;
                py = -xs;
                pz = HALF_PI;
            end else begin
                px = -ys;
                py = xs;
                pz = -HALF_PI;
            end
        end
    end

    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (y_q[18]) begin
            x_n = x_q - y_sh;
            y_n = y_q + x_sh;
            z_n = z_q - atan_rom(cnt_q);
        end else begin
            x_n = x_q + y_sh;
            y_n = y_q - x_sh;
            z_n = z_q + atan_rom(cnt_q);
        end
    end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    always_comb prod = 34'(x_q) * KGAIN;
    always_comb src  = g_q;
`else
    always_comb src  = x_q;
`endif

    // The zero vector has no defined angle; the iterations would otherwise sum the whole ROM.
    always_comb begin
        mag_c = src[15:0];
        if (zero_q || src[18]) mag_c = 16'h0000;
        else if (src > 19'sd32767) mag_c = 16'h7FFF;
        ang_c = z_q;
        if (zero_q)          ang_c = 16'sd0;
        else if (z_q > PI)   ang_c = PI;
        else if (z_q < -PI)  ang_c = -PI;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            mag    <= '0;
            ang    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            g_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            busy <= (state_d != IDLE);
            if (state_q == DONE) begin
                mag  <= mag_c;
                ang  <= ang_c;
                done <= 1'b1;
            end
            if (start) begin
                x_q    <= px;
                y_q    <= py;
                z_q    <= pz;
                cnt_q  <= '0;
                zero_q <= (x_in == 16'h0000) && (y_in == 16'h0000);
            end else if (state_q == ROT) begin
                x_q   <= x_n;
                y_q   <= y_n;
                z_q   <= z_n;
                cnt_q <= cnt_q + 4'd1;
            end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            if (state_q == GAIN) g_q <= 19'(prod >>> 14);
`endif
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed vectors, busy/en handling, back-to-back and reset abort.
// Expected results come from a real-valued atan2/hypot model queued at en time and popped on done.
module tb_cordic_vector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] x_in = 16'h0000;
    logic [15:0] y_in = 16'h0000;
    logic [15:0] mag, ang;
    logic        done, busy;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    localparam int  LAT = 16;
    localparam real GK  = 1.0;
`else
    localparam int  LAT = 15;
    localparam real GK  = 1.646760;
`endif

    typedef struct {
        logic [15:0] mag;
        logic [15:0] ang;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ndone = 0;

    cordic_vector #(.ITER(14)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .x_in (x_in),
        .y_in (y_in),
        .mag  (mag),
        .ang  (ang),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        int diff;
        diff = obs - expv;
        checks++;
        assert ((diff <= tol) && (diff >= -tol)) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    function automatic void model(input int x, input int y, output int em, output int ea);
        real xr, yr, m;
        xr = real'(x);
        yr = real'(y);
        if (x == 0 && y == 0) begin
            em = 0;
            ea = 0;
        end else begin
            m  = $sqrt(xr * xr + yr * yr) * GK;
            em = (m > 32767.0) ? 32767 : int'(m);
            ea = int'($atan2(yr, xr) * 8192.0);
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   em, ea;
        model(int'($signed(x)), int'($signed(y)), em, ea);
        e.mag   = 16'(em);
        e.ang   = 16'(ea);
        e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic op(input logic [15:0] x, input logic [15:0] y, input bit push);
        x_in = x;
        y_in = y;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        if (push) push_exp(x, y);
    endtask

    // Scoreboard: every done pops the oldest expectation and checks values and latency.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            ndone++;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done: observed=1 expected=0 at cycle %0d", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk_tol("mag", int'(mag), int'(e.mag), 4);
                chk_tol("ang", int'($signed(ang)), int'($signed(e.ang)), 3);
                chk_eq("latency", cyc - e.start, LAT);
            end
        end
    end

    logic [15:0] vx [10] = '{16'h4000, 16'h2D41, 16'hC000, 16'h0000, 16'h7FFF,
                             16'h0000, 16'hD000, 16'h1234, 16'hE000, 16'h3000};
    logic [15:0] vy [10] = '{16'h0000, 16'h2D41, 16'h0000, 16'hC000, 16'h7FFF,
                             16'h0000, 16'hF000, 16'h5678, 16'h3000, 16'hB000};

    initial begin
        int nd0;
        int t;

        wait_cyc(3);
        chk_eq("reset_mag", int'(mag), 0);
        chk_eq("reset_ang", int'(ang), 0);
        chk_eq("reset_done", int'(done), 0);
        chk_eq("reset_busy", int'(busy), 0);
        rst = 1'b1;
        wait_cyc(1);

        for (int i = 0; i < 10; i++) begin
            op(vx[i], vy[i], 1'b1);
            chk_eq("busy_during_op", int'(busy), 1);
            wait_cyc(LAT + 2);
            chk_eq("busy_after_op", int'(busy), 0);
        end

        // en held through the busy window with different operands must be ignored
        nd0  = ndone;
        x_in = 16'h4000;
        y_in = 16'h0000;
        en   = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h4000, 16'h0000);
        x_in = 16'h7FFF;
        y_in = 16'h8000;
        wait_cyc(4);
        chk_eq("busy_en_held", int'(busy), 1);
        en = 1'b0;
        wait_cyc(LAT);
        chk_eq("en_held_done_count", ndone - nd0, 1);

        // en in the DONE cycle starts the next operation back-to-back
        nd0 = ndone;
        op(16'h2D41, 16'h2D41, 1'b1);
        wait_cyc(LAT - 1);
        op(16'h0000, 16'hC000, 1'b1);
        chk_eq("b2b_busy", int'(busy), 1);
        wait_cyc(LAT + 2);
        chk_eq("b2b_done_count", ndone - nd0, 2);

        // reset five cycles into an operation; en during reset must not start anything
        nd0 = ndone;
        op(16'h2D41, 16'h2D41, 1'b0);
        wait_cyc(4);
        rst  = 1'b0;
        en   = 1'b1;
        x_in = 16'h4000;
        y_in = 16'h0000;
        wait_cyc(1);
        rst = 1'b1;
        en  = 1'b0;
        chk_eq("abort_mag", int'(mag), 0);
        chk_eq("abort_ang", int'(ang), 0);
        chk_eq("abort_done", int'(done), 0);
        chk_eq("abort_busy", int'(busy), 0);
        wait_cyc(LAT + 3);
        chk_eq("abort_no_done", ndone - nd0, 0);
        chk_eq("abort_idle_busy", int'(busy), 0);

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            wait_cyc(1);
            t++;
        end
        chk_eq("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
